cs2fifoc: RTL and testbench

//  Builds the configuration echo/reply packet from the decoded command-set registers and streams it into the TX FIFO.

---
 rtl/cs2fifoc_pkg.sv | 47 ++++
 rtl/cs2fifoc.sv | 128 ++++++++++++
 tb/tb_cs2fifoc.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cs2fifoc_pkg.sv
// Shared definitions for the config reply packet builder (cs2fifoc) and the
// command decoder: state codes, header word, packet length and payload order.
package cs2fifoc_pkg;

    localparam int          PKT_LEN = 12;
    localparam logic [15:0] HEAD    = 16'h55AA;

    // Index of the last byte written from SEND; the checksum byte follows it.
    localparam logic [3:0] LAST_SEND_IDX = 4'(PKT_LEN - 2);

    // Payload byte positions inside the packet, shared with the decoder.
    localparam logic [3:0] POS_HEAD_HI  = 4'd0;
    localparam logic [3:0] POS_HEAD_LO  = 4'd1;
    localparam logic [3:0] POS_KIND_DEV = 4'd2;
    localparam logic [3:0] POS_INFO_SR  = 4'd3;
    localparam logic [3:0] POS_CMD_FILT = 4'd4;
    localparam logic [3:0] POS_CMD_MIX0 = 4'd5;
    localparam logic [3:0] POS_CMD_REG4 = 4'd6;
    localparam logic [3:0] POS_CMD_REG5 = 4'd7;
    localparam logic [3:0] POS_CMD_REG6 = 4'd8;
    localparam logic [3:0] POS_CMD_REG7 = 4'd9;
    localparam logic [3:0] POS_CMD_MIX1 = 4'd10;
    localparam logic [3:0] POS_CSUM     = 4'd11;

    // Debug-visible state codes.
    typedef enum logic [7:0] {
        ST_IDLE = 8'h00,
        ST_LOAD = 8'h01,
        ST_SEND = 8'h02,
        ST_CSUM = 8'h03,
        ST_LAST = 8'h0F
    } state_t;

    // Snapshot of the nine payload bytes, first-sent byte in the MSBs.
    typedef struct packed {
        logic [7:0] kind_dev;
        logic [7:0] info_sr;
        logic [7:0] cmd_filt;
        logic [7:0] cmd_mix0;
        logic [7:0] cmd_reg4;
        logic [7:0] cmd_reg5;
        logic [7:0] cmd_reg6;
        logic [7:0] cmd_reg7;
        logic [7:0] cmd_mix1;
    } payload_t;

endpackage

// File: rtl/cs2fifoc.sv
// Config reply packet builder: snapshots the decoded command-set registers and
// streams header, payload and checksum into the TX FIFO under fs/fd handshake.
module cs2fifoc
    import cs2fifoc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       fs,
    output logic       fd,
    input  logic       err,
    input  logic [7:0] kind_dev,
    input  logic [7:0] info_sr,
    input  logic [7:0] cmd_filt,
    input  logic [7:0] cmd_mix0,
    input  logic [7:0] cmd_reg4,
    input  logic [7:0] cmd_reg5,
    input  logic [7:0] cmd_reg6,
    input  logic [7:0] cmd_reg7,
    input  logic [7:0] cmd_mix1,
    input  logic       fifoc_full,
    output logic       fifoc_txen,
    output logic [7:0] fifoc_txd,
    output logic [7:0] so
);

    state_t     state;
    state_t     state_next;
    payload_t   snap;
    logic [3:0] idx;
    logic [7:0] sum;
    logic [7:0] cur_byte;

    assign so = state;

    // Select the packet byte addressed by idx.
    always_comb begin
        cur_byte = 8'h00;
        case (idx)
            POS_HEAD_HI:  cur_byte = HEAD[15:8];
            POS_HEAD_LO:  cur_byte = HEAD[7:0];
            POS_KIND_DEV: cur_byte = snap.kind_dev;
            POS_INFO_SR:  cur_byte = snap.info_sr;
            POS_CMD_FILT: cur_byte = snap.cmd_filt;
            POS_CMD_MIX0: cur_byte = snap.cmd_mix0;
            POS_CMD_REG4: cur_byte = snap.cmd_reg4;
            POS_CMD_REG5: cur_byte = snap.cmd_reg5;
            POS_CMD_REG6: cur_byte = snap.cmd_reg6;
            POS_CMD_REG7: cur_byte = snap.cmd_reg7;
            POS_CMD_MIX1: cur_byte = snap.cmd_mix1;
            POS_CSUM:     cur_byte = sum;
            default:      cur_byte = 8'h00;
        endcase
    end

    // State register; reset aborts any packet in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and FIFO write outputs; writes only advance while FIFO not full.
    always_comb begin
        state_next = state;
        fd         = 1'b0;
        fifoc_txen = 1'b0;
        fifoc_txd  = 8'h00;
        case (state)
            ST_IDLE: begin
                if (fs) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_next = ST_SEND;
            end
            ST_SEND: begin
                fifoc_txen = !fifoc_full;
                fifoc_txd  = cur_byte;
                if (!fifoc_full && idx == LAST_SEND_IDX) begin
                    state_next = ST_CSUM;
                end
            end
            ST_CSUM: begin
                fifoc_txen = !fifoc_full;
                fifoc_txd  = sum;
                if (!fifoc_full) begin
                    state_next = ST_LAST;
                end
            end
            ST_LAST: begin
                fd = 1'b1;
                if (!fs) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Payload snapshot, byte index and running checksum over the payload bytes.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap <= '0;
            idx  <= 4'd0;
            sum  <= 8'h00;
        end else if (state == ST_LOAD) begin
            if (err) begin
                snap <= '1;
            end else begin
                snap <= '{kind_dev, info_sr, cmd_filt, cmd_mix0,
                          cmd_reg4, cmd_reg5, cmd_reg6, cmd_reg7, cmd_mix1};
            end
            idx <= 4'd0;
            sum <= 8'h00;
        end else if (state == ST_SEND && !fifoc_full) begin
            idx <= idx + 4'd1;
            if (idx >= POS_KIND_DEV) begin
                sum <= sum + cur_byte;
            end
        end
    end

endmodule

// File: tb/tb_cs2fifoc.sv
// Self-checking bench for cs2fifoc: directed scenarios plus randomized packets
// compared against a list-based model of the reply packet.
module tb_cs2fifoc;

    logic       clk = 1'b0;
    logic       rst;
    logic       fs;
    logic       fd;
    logic       err;
    logic [7:0] kind_dev, info_sr, cmd_filt, cmd_mix0;
    logic [7:0] cmd_reg4, cmd_reg5, cmd_reg6, cmd_reg7, cmd_mix1;
    logic       fifoc_full;
    logic       fifoc_txen;
    logic [7:0] fifoc_txd;
    logic [7:0] so;

    always #5 clk = ~clk;

    cs2fifoc dut (
        .clk(clk), .rst(rst), .fs(fs), .fd(fd), .err(err),
        .kind_dev(kind_dev), .info_sr(info_sr), .cmd_filt(cmd_filt),
        .cmd_mix0(cmd_mix0), .cmd_reg4(cmd_reg4), .cmd_reg5(cmd_reg5),
        .cmd_reg6(cmd_reg6), .cmd_reg7(cmd_reg7), .cmd_mix1(cmd_mix1),
        .fifoc_full(fifoc_full), .fifoc_txen(fifoc_txen),
        .fifoc_txd(fifoc_txd), .so(so)
    );

    logic [7:0] fields [9];
    logic [7:0] got [$];
    logic [7:0] exp_q [$];
    int         first_w, last_w, fd_c;
    bit         aborted;
    int         tests_run = 0;
    int         tests_failed = 0;

    task automatic drive_fields();
        kind_dev = fields[0]; info_sr  = fields[1]; cmd_filt = fields[2];
        cmd_mix0 = fields[3]; cmd_reg4 = fields[4]; cmd_reg5 = fields[5];
        cmd_reg6 = fields[6]; cmd_reg7 = fields[7]; cmd_mix1 = fields[8];
    endtask

    task automatic zero_inputs();
        kind_dev = 8'h00; info_sr  = 8'h00; cmd_filt = 8'h00;
        cmd_mix0 = 8'h00; cmd_reg4 = 8'h00; cmd_reg5 = 8'h00;
        cmd_reg6 = 8'h00; cmd_reg7 = 8'h00; cmd_mix1 = 8'h00;
        err = 1'b0;
    endtask

    task automatic count_fields();
        for (int i = 0; i < 9; i++) fields[i] = 8'(i + 1);
    endtask

    // Reference packet: header, nine payload bytes (all FF on error), 8-bit sum.
    function automatic void build_expected(input bit e);
        logic [7:0] s = 8'h00;
        logic [7:0] b;
        exp_q.delete();
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hAA);
        for (int i = 0; i < 9; i++) begin
            b = e ? 8'hFF : fields[i];
            exp_q.push_back(b);
            s = s + b;
        end
        exp_q.push_back(s);
    endfunction

    // Index of first differing byte over the common prefix, or -1.
    function automatic int first_mismatch();
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            if (got[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    // Raise fs and collect written bytes until fd, a reset point, or timeout.
    task automatic run_packet(input int full_pct, input int stall_at, input int stall_len,
                              input bit zero_after_load, input int rst_after, input int drop_fs_at);
        int  stall_left = 0;
        bit  stall_done = 0;
        got.delete();
        first_w = -1; last_w = -1; fd_c = -1; aborted = 0;
        @(negedge clk);
        fs = 1'b1;
        fifoc_full = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (zero_after_load && c == 1) zero_inputs();
            if (drop_fs_at >= 0 && c == drop_fs_at) fs = 1'b0;
            if (stall_at >= 0 && !stall_done && got.size() == stall_at) begin
                stall_left = stall_len;
                stall_done = 1;
            end
            if (stall_left > 0) begin
                fifoc_full = 1'b1;
                stall_left--;
            end else begin
                fifoc_full = (full_pct > 0) && (int'($urandom_range(99)) < full_pct);
            end
            #1;
            if (c == 0) begin
                tests_run++;
                if (so !== 8'h01) begin
                    tests_failed++;
                    $display("[TB] FAIL load_state: got %h expected 01", so);
                end
            end
            if (fifoc_full && c >= 1 && got.size() < 12) begin
                tests_run++;
                if (fifoc_txen !== 1'b0 || fifoc_txd !== exp_q[got.size()]) begin
                    tests_failed++;
                    $display("[TB] FAIL stall_hold: txen %b txd %h expected txen 0 txd %h",
                             fifoc_txen, fifoc_txd, exp_q[got.size()]);
                end
            end
            if (fifoc_txen === 1'b1) begin
                if (first_w < 0) first_w = c;
                last_w = c;
                got.push_back(fifoc_txd);
            end
            if (fd === 1'b1) begin
                fd_c = c;
                break;
            end
            if (rst_after >= 0 && got.size() == rst_after) begin
                aborted = 1;
                break;
            end
        end
        fifoc_full = 1'b0;
        if (fd_c < 0 && !aborted) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL timeout: got %0d bytes expected fd within 400 cycles", got.size());
        end
    endtask

    // Check a completed packet's bytes and write timing.
    task automatic check_packet(input string name, input bit unstalled);
        int m;
        tests_run++;
        m = first_mismatch();
        if (got.size() != 12 || m != -1) begin
            tests_failed++;
            $display("[TB] FAIL %s_bytes: got %0d bytes (first diff at %0d) expected 12 matching model",
                     name, got.size(), m);
        end
        tests_run++;
        if (fd_c != last_w + 1) begin
            tests_failed++;
            $display("[TB] FAIL %s_fd_delay: got fd at %0d expected %0d", name, fd_c, last_w + 1);
        end
        if (unstalled) begin
            tests_run++;
            if (first_w != 1 || last_w != 12) begin
                tests_failed++;
                $display("[TB] FAIL %s_latency: got writes %0d..%0d expected 1..12", name, first_w, last_w);
            end
        end
    endtask

    // Drop fs after fd and confirm return to IDLE on the next clock.
    task automatic end_packet(input string name);
        fs = 1'b0;
        @(negedge clk);
        #1;
        tests_run++;
        if (fd !== 1'b0 || so !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL %s_idle: got fd %b so %h expected fd 0 so 00", name, fd, so);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; fs = 1'b0; fifoc_full = 1'b0;
        zero_inputs();
        repeat (2) @(negedge clk);
        #1;
        tests_run++;
        if (fd !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_fd: got %b expected 0", fd); end
        tests_run++;
        if (fifoc_txen !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_txen: got %b expected 0", fifoc_txen); end
        tests_run++;
        if (fifoc_txd !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_txd: got %h expected 00", fifoc_txd); end
        tests_run++;
        if (so !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_so: got %h expected 00", so); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        count_fields(); drive_fields(); err = 1'b0;
        build_expected(0);
        run_packet(0, -1, 0, 0, -1, -1);
        check_packet("basic", 1);
        tests_run++;
        if (got.size() != 12 || got[11] !== 8'h2D) begin
            tests_failed++;
            $display("[TB] FAIL basic_csum: got %h expected 2d", got.size() == 12 ? got[11] : 8'hxx);
        end
        end_packet("basic");
    endtask

    task automatic test_err();
        count_fields(); drive_fields(); err = 1'b1;
        build_expected(1);
        run_packet(0, -1, 0, 0, -1, -1);
        check_packet("err", 1);
        tests_run++;
        if (got.size() != 12 || got[11] !== 8'hF7) begin
            tests_failed++;
            $display("[TB] FAIL err_csum: got %h expected f7", got.size() == 12 ? got[11] : 8'hxx);
        end
        err = 1'b0;
        end_packet("err");
    endtask

    task automatic test_stall();
        count_fields(); drive_fields(); err = 1'b0;
        build_expected(0);
        run_packet(0, 5, 3, 0, -1, -1);
        check_packet("stall", 0);
        tests_run++;
        if (last_w - first_w != 14) begin
            tests_failed++;
            $display("[TB] FAIL stall_span: got %0d expected 14", last_w - first_w);
        end
        end_packet("stall");
    endtask

    task automatic test_snapshot();
        count_fields(); drive_fields(); err = 1'b0;
        build_expected(0);
        run_packet(0, -1, 0, 1, -1, -1);
        check_packet("snapshot", 1);
        tests_run++;
        if (got.size() != 12 || got[11] !== 8'h2D) begin
            tests_failed++;
            $display("[TB] FAIL snapshot_csum: got %h expected 2d", got.size() == 12 ? got[11] : 8'hxx);
        end
        end_packet("snapshot");
    endtask

    task automatic test_reset_mid();
        count_fields(); drive_fields(); err = 1'b0;
        build_expected(0);
        run_packet(0, -1, 0, 0, 6, -1);
        tests_run++;
        if (!aborted || first_mismatch() != -1) begin
            tests_failed++;
            $display("[TB] FAIL rstmid_prefix: got %0d bytes diff at %0d expected 6 matching",
                     got.size(), first_mismatch());
        end
        @(negedge clk);
        rst = 1'b1; fs = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests_run++;
        if (so !== 8'h00 || fifoc_txen !== 1'b0 || fd !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL rstmid_idle: got so %h txen %b fd %b expected 00 0 0", so, fifoc_txen, fd);
        end
        run_packet(0, -1, 0, 0, -1, -1);
        check_packet("rstmid_new", 1);
        end_packet("rstmid_new");
    endtask

    task automatic test_hold_fs();
        logic [7:0] s;
        for (int i = 0; i < 9; i++) fields[i] = 8'($urandom);
        drive_fields(); err = 1'b0;
        build_expected(0);
        run_packet(0, -1, 0, 0, -1, -1);
        check_packet("hold", 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            tests_run++;
            if (fd !== 1'b1 || fifoc_txen !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL hold_fd: got fd %b txen %b expected 1 0", fd, fifoc_txen);
            end
        end
        end_packet("hold");
        tests_run++;
        if (got.size() != 12) begin
            tests_failed++;
            $display("[TB] FAIL loopback_len: got %0d expected 12", got.size());
        end else begin
            s = 8'h00;
            for (int i = 2; i <= 10; i++) s = s + got[i];
            if (got[0] !== 8'h55 || got[1] !== 8'hAA || got[11] !== s) begin
                tests_failed++;
                $display("[TB] FAIL loopback_err: got hdr %h%h csum %h expected 55aa csum %h",
                         got[0], got[1], got[11], s);
            end
            for (int i = 0; i < 9; i++) begin
                tests_run++;
                if (got[2 + i] !== fields[i]) begin
                    tests_failed++;
                    $display("[TB] FAIL loopback_field%0d: got %h expected %h", i, got[2 + i], fields[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        bit e;
        int drop;
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < 9; i++) fields[i] = 8'($urandom);
            e = ($urandom_range(3) == 0);
            drop = ($urandom_range(2) == 0) ? int'($urandom_range(2, 10)) : -1;
            drive_fields(); err = e;
            build_expected(e);
            run_packet(30, -1, 0, 0, -1, drop);
            check_packet("random", 0);
            end_packet("random");
        end
        err = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_err();
        test_stall();
        test_snapshot();
        test_reset_mid();
        test_hold_fs();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
